disaggregator: RTL and testbench
================================

# disaggregator

Wide-to-narrow stream splitter: dequeues one packed word of `FETCH_WIDTH` lanes from an upstream FIFO and enqueues its lanes one per cycle, lane 0 first, into a narrow downstream FIFO. It is the inverse of the aggregator and sits where packed words return to a per-element stream. Active lane count is runtime-selectable via `change_fetch_width`/`input_fetch_width`, matching the aggregator's control pair.

## Interface
- `DATA_WIDTH`, 8, bits per lane
- `FETCH_WIDTH`, 6, maximum lanes per wide word (>= 2)
- `clk  in  1` — single clock
- `rst_n  in  1` — asynchronous, active-low reset
- `sender_data  in  FETCH_WIDTH*DATA_WIDTH` — wide word; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- `sender_empty_n  in  1` — upstream FIFO holds a word; `sender_data` valid while high
- `sender_deq  out  1` — pop upstream; `sender_data` captured in the same cycle
- `receiver_data  out  DATA_WIDTH` — current lane
- `receiver_full_n  in  1` — downstream has space
- `receiver_enq  out  1` — push `receiver_data` downstream
- `change_fetch_width  in  1` — load `input_fetch_width`
- `input_fetch_width  in  $clog2(FETCH_WIDTH)+1` — requested lane count

## Operation
- State: held wide word `buf`, lane counter `rem` (lanes left), width register `fw`. `buf` non-empty iff `rem != 0`.
- Width: `fw` resets to `FETCH_WIDTH`. In any cycle with `change_fetch_width=1`, the next width is `input_fetch_width`; values 0 or > `FETCH_WIDTH` clamp to `FETCH_WIDTH`. `fw` updates only when no word is held, or in the same cycle a new word is captured (the captured word uses the new width). A request while busy is held pending and applied at the next capture; the latest request wins.
- Capture: `sender_deq = sender_empty_n && (rem == 0 || (rem == 1 && receiver_enq))`. On capture, `buf` ← `sender_data` and `rem` ← effective width. Lanes >= width are discarded.
- Emit: `receiver_enq = (rem != 0) && receiver_full_n`. `receiver_data` = `buf[DATA_WIDTH-1:0]`. On enq, `buf` shifts right by `DATA_WIDTH` and `rem` decrements.
- Enq and capture in the same cycle (last lane) give a gapless stream. `receiver_full_n=0` freezes `buf`/`rem` with no loss.
- `receiver_data` is 0 whenever `rem == 0`.

## Timing
- Reset: `buf=0`, `rem=0`, `fw=FETCH_WIDTH`, pending cleared. `sender_deq=0`, `receiver_enq=0`, `receiver_data=0`. Reset mid-word discards remaining lanes.
- Latency: capture at edge N, lane 0 enqueued in cycle N+1 (first enq-qualified cycle after capture).
- Throughput: 1 lane/cycle sustained. A W-lane word occupies W cycles when the receiver does not stall.
- `sender_deq` and `receiver_enq` are combinational from registered state plus the handshake inputs. There is no combinational path from `sender_data` to any output.

## Configuration
- `DISAGGREGATOR_PREFETCH_EN` defined: adds a second wide slot `nxt` (with its own width). `sender_deq = sender_empty_n && nxt empty`. When `rem` reaches 0 (or on the last-lane enq), `nxt` moves into `buf` with no bubble. This decouples upstream pop from drain, so the upstream can be popped up to one word ahead.
- Undefined: single slot, capture rule as above. Ports and lane order are identical in both builds.

## Structure
- The shared stream package holds the lane-count width (`$clog2(FETCH_WIDTH)+1`) and the width clamp function. The aggregator uses the same clamp.
- Sub-module `disagg_lane_buffer`: wide register, shift-on-pop, `rem` counter, load port. Instantiate it once, or twice with `DISAGGREGATOR_PREFETCH_EN` (`nxt` feeding `buf`).

## Test plan
All scenarios use DATA_WIDTH=8, FETCH_WIDTH=6.
- Reset, then one word lanes 0x05..0x00 = {05,04,03,02,01,00}, receiver always ready → 6 consecutive enqs 00,01,02,03,04,05; `sender_deq` once; then idle with `receiver_data=0`.
- Two words queued back-to-back, receiver ready → 12 enqs with no gap; second `sender_deq` coincides with the enq of lane 5 (prefetch build: second deq 1 cycle after the first).
- `change_fetch_width=1`, width 4, then word {..,13,12,11,10} → enqs 10,11,12,13 only; lanes 4–5 dropped. Width 0 or 7 → 6 lanes.
- Width change to 2 raised while a 6-lane word is at lane 2 → current word still emits 6 lanes; next word emits 2.
- Random `receiver_full_n` (50%) with random `sender_empty_n` over 200 words of incrementing lanes → downstream sequence strictly incrementing, no duplicates or drops.
- `rst_n` low for 1 cycle at lane 3 → `receiver_enq=0` immediately (async); next word after release starts at its lane 0.

Source files
------------

// File: rtl/disaggregator_pkg.sv
// Shared stream definitions for the aggregator/disaggregator pair: default geometry,
// lane-count width and the runtime lane-count clamp.
package disaggregator_pkg;

    localparam int unsigned DefDataWidth  = 8;
    localparam int unsigned DefFetchWidth = 6;

    // Lane counters must hold the value FETCH_WIDTH itself, hence the extra bit.
    function automatic int unsigned lane_cnt_width(input int unsigned fetch_width);
        return $clog2(fetch_width) + 1;
    endfunction

    // A request of zero or beyond the physical width selects the full width.
    function automatic int unsigned clamp_width(input int unsigned req,
                                                input int unsigned fetch_width);
        if (req == 0 || req > fetch_width) begin
            return fetch_width;
        end
        return req;
    endfunction

endpackage

// File: rtl/disagg_lane_buffer.sv
// One wide slot: holds a packed word and the count of lanes still to emit.
// Load wins over clear, clear wins over pop; pop shifts the word down by one lane.
module disagg_lane_buffer
    import disaggregator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned FETCH_WIDTH = DefFetchWidth,
    localparam int unsigned CntW       = lane_cnt_width(FETCH_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] load_data,
    input  logic [CntW-1:0]                 load_cnt,
    input  logic                            clear,
    input  logic                            pop,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] word,
    output logic [CntW-1:0]                 cnt
);

    logic [FETCH_WIDTH*DATA_WIDTH-1:0] word_q, word_d;
    logic [CntW-1:0]                   cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load) begin
            word_d = load_data;
            cnt_d  = load_cnt;
        end else if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (pop && cnt_q != '0) begin
            word_d = word_q >> DATA_WIDTH;
            cnt_d  = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word = word_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/disaggregator.sv
// Wide-to-narrow stream splitter: pops packed words upstream and pushes lanes one per
// cycle, lane 0 first. Define DISAGGREGATOR_PREFETCH_EN for a second (prefetch) slot.
module disaggregator
    import disaggregator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned FETCH_WIDTH = DefFetchWidth,
    localparam int unsigned CntW       = lane_cnt_width(FETCH_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                            sender_empty_n,
    output logic                            sender_deq,
    output logic [DATA_WIDTH-1:0]           receiver_data,
    input  logic                            receiver_full_n,
    output logic                            receiver_enq,
    input  logic                            change_fetch_width,
    input  logic [CntW-1:0]                 input_fetch_width
);

    logic [FETCH_WIDTH*DATA_WIDTH-1:0] buf_word;
    logic [CntW-1:0]                   buf_cnt;
    logic                              buf_load;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] buf_load_data;
    logic [CntW-1:0]                   buf_load_cnt;
    logic                              buf_free;
    logic                              held;

    logic [CntW-1:0] fw_q, fw_d;
    logic            pend_q, pend_d;
    logic [CntW-1:0] pend_w_q, pend_w_d;
    logic [CntW-1:0] req_w;
    logic [CntW-1:0] eff_w;

    // Only the low lane of the output slot is ever presented downstream.
    logic unused_buf_upper;
    assign unused_buf_upper = ^buf_word[FETCH_WIDTH*DATA_WIDTH-1:DATA_WIDTH];

    assign req_w = CntW'(clamp_width(32'(input_fetch_width), FETCH_WIDTH));
    assign eff_w = change_fetch_width ? req_w : (pend_q ? pend_w_q : fw_q);

    assign receiver_enq  = (buf_cnt != '0) && receiver_full_n;
    assign receiver_data = (buf_cnt != '0) ? buf_word[DATA_WIDTH-1:0] : '0;
    // Output slot empties at this edge: either already empty or emitting its last lane.
    assign buf_free      = (buf_cnt == '0) || (buf_cnt == CntW'(1) && receiver_enq);

`ifdef DISAGGREGATOR_PREFETCH_EN
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] nxt_word;
    logic [CntW-1:0]                   nxt_cnt;
    logic                              nxt_empty;
    logic                              direct;
    logic                              move;

    assign nxt_empty  = (nxt_cnt == '0);
    assign sender_deq = sender_empty_n && nxt_empty;
    // With both slots free the popped word bypasses nxt so first-lane latency is unchanged.
    assign direct     = buf_free && nxt_empty;
    assign move       = buf_free && !nxt_empty;

    assign buf_load      = move || (sender_deq && direct);
    assign buf_load_data = move ? nxt_word : sender_data;
    assign buf_load_cnt  = move ? nxt_cnt : eff_w;
    assign held          = (buf_cnt != '0) || !nxt_empty;

    disagg_lane_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_nxt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sender_deq && !direct),
        .load_data (sender_data),
        .load_cnt  (eff_w),
        .clear     (move),
        .pop       (1'b0),
        .word      (nxt_word),
        .cnt       (nxt_cnt)
    );
`else
    assign sender_deq    = sender_empty_n && buf_free;
    assign buf_load      = sender_deq;
    assign buf_load_data = sender_data;
    assign buf_load_cnt  = eff_w;
    assign held          = (buf_cnt != '0);
`endif

    disagg_lane_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .load_data (buf_load_data),
        .load_cnt  (buf_load_cnt),
        .clear     (1'b0),
        .pop       (receiver_enq),
        .word      (buf_word),
        .cnt       (buf_cnt)
    );

    // Width may only move while idle or at a capture; otherwise park the latest request.
    always_comb begin
        fw_d     = fw_q;
        pend_d   = pend_q;
        pend_w_d = pend_w_q;
        if (sender_deq || !held) begin
            fw_d   = eff_w;
            pend_d = 1'b0;
        end else if (change_fetch_width) begin
            pend_d   = 1'b1;
            pend_w_d = req_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_q     <= CntW'(FETCH_WIDTH);
            pend_q   <= 1'b0;
            pend_w_q <= '0;
        end else begin
            fw_q     <= fw_d;
            pend_q   <= pend_d;
            pend_w_q <= pend_w_d;
        end
    end

endmodule

// File: tb/tb_disaggregator.sv
// Directed bench for disaggregator (default single-slot build, DATA_WIDTH=8, FETCH_WIDTH=6).
module tb_disaggregator;

    localparam int DW = 8;
    localparam int FW = 6;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [FW*DW-1:0] sender_data;
    logic             sender_empty_n;
    logic             sender_deq;
    logic [DW-1:0]    receiver_data;
    logic             receiver_full_n;
    logic             receiver_enq;
    logic             change_fetch_width;
    logic [CW-1:0]    input_fetch_width;

    always #5 clk = ~clk;

    disaggregator #(
        .DATA_WIDTH  (DW),
        .FETCH_WIDTH (FW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .sender_data        (sender_data),
        .sender_empty_n     (sender_empty_n),
        .sender_deq         (sender_deq),
        .receiver_data      (receiver_data),
        .receiver_full_n    (receiver_full_n),
        .receiver_enq       (receiver_enq),
        .change_fetch_width (change_fetch_width),
        .input_fetch_width  (input_fetch_width)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [FW*DW-1:0] src_q[$];
    logic [DW-1:0]    got[$];
    bit               src_gate = 1'b1;
    bit               rcv_gate = 1'b1;
    logic             s_deq, s_enq;
    logic [DW-1:0]    s_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW*DW-1:0] mk_word(input logic [7:0] base);
        logic [FW*DW-1:0] w;
        for (int i = 0; i < FW; i++) w[i*DW +: DW] = base + 8'(i);
        return w;
    endfunction

    // Called at posedge+1: drive, sample mid-cycle, model both FIFOs, advance one edge.
    task automatic run_cycle();
        sender_empty_n  = (src_q.size() != 0) && src_gate;
        sender_data     = (src_q.size() != 0) ? src_q[0] : '0;
        receiver_full_n = rcv_gate;
        #3;
        s_deq  = sender_deq;
        s_enq  = receiver_enq;
        s_data = receiver_data;
        if (s_enq) got.push_back(s_data);
        if (s_deq && src_q.size() != 0) void'(src_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int errs;

        rst_n              = 1'b0;
        sender_data        = '0;
        sender_empty_n     = 1'b0;
        receiver_full_n    = 1'b0;
        change_fetch_width = 1'b0;
        input_fetch_width  = '0;
        #12;
        check("rst_enq", 32'(receiver_enq), 0);
        check("rst_deq", 32'(sender_deq), 0);
        check("rst_data", 32'(receiver_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word, receiver always ready
        src_q.push_back(mk_word(8'h00));
        run_cycle();
        check("w1_capture_deq", 32'(s_deq), 1);
        check("w1_capture_enq", 32'(s_enq), 0);
        for (int i = 0; i < FW; i++) begin
            run_cycle();
            check("w1_enq", 32'(s_enq), 1);
            check("w1_data", 32'(s_data), 32'(i));
            check("w1_deq", 32'(s_deq), 0);
        end
        run_cycle();
        check("w1_idle_enq", 32'(s_enq), 0);
        check("w1_idle_data", 32'(s_data), 0);

        // Two words back to back: gapless, second pop on the last lane
        src_q.push_back(mk_word(8'h10));
        src_q.push_back(mk_word(8'h16));
        run_cycle();
        check("b2b_first_deq", 32'(s_deq), 1);
        for (int i = 0; i < 2 * FW; i++) begin
            run_cycle();
            check("b2b_enq", 32'(s_enq), 1);
            check("b2b_data", 32'(s_data), 32'(8'h10 + i));
            check("b2b_deq", 32'(s_deq), (i == FW - 1) ? 1 : 0);
        end
        run_cycle();
        check("b2b_idle_enq", 32'(s_enq), 0);

        // Width 4: upper two lanes dropped
        change_fetch_width = 1'b1;
        input_fetch_width  = 4'd4;
        run_cycle();
        change_fetch_width = 1'b0;
        got.delete();
        src_q.push_back(mk_word(8'h20));
        repeat (7) run_cycle();
        check("fw4_count", got.size(), 4);
        for (int i = 0; i < 4; i++) check("fw4_data", 32'(got[i]), 32'(8'h20 + i));

        // Width 0 and 7 clamp to 6
        change_fetch_width = 1'b1;
        input_fetch_width  = 4'd0;
        run_cycle();
        change_fetch_width = 1'b0;
        got.delete();
        src_q.push_back(mk_word(8'h30));
        repeat (8) run_cycle();
        check("fw0_count", got.size(), 6);
        check("fw0_last", (got.size() == 6) ? 32'(got[5]) : 32'hffff, 32'h35);

        change_fetch_width = 1'b1;
        input_fetch_width  = 4'd7;
        run_cycle();
        change_fetch_width = 1'b0;
        got.delete();
        src_q.push_back(mk_word(8'h38));
        repeat (8) run_cycle();
        check("fw7_count", got.size(), 6);
        check("fw7_last", (got.size() == 6) ? 32'(got[5]) : 32'hffff, 32'h3d);

        // Width change to 2 while busy at lane 2: applies to the next word only
        got.delete();
        src_q.push_back(mk_word(8'h40));
        src_q.push_back(mk_word(8'h50));
        repeat (3) run_cycle();
        change_fetch_width = 1'b1;
        input_fetch_width  = 4'd2;
        run_cycle();
        change_fetch_width = 1'b0;
        repeat (10) run_cycle();
        check("pend_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            check("pend_data", 32'(got[i]), (i < 6) ? 32'(8'h40 + i) : 32'(8'h50 + i - 6));
        end

        // Restore full width, then random back-pressure on both sides
        change_fetch_width = 1'b1;
        input_fetch_width  = 4'd6;
        run_cycle();
        change_fetch_width = 1'b0;
        got.delete();
        for (int k = 0; k < 200; k++) src_q.push_back(mk_word(8'(k * 6)));
        cycles = 0;
        while (got.size() < 200 * FW && cycles < 20000) begin
            src_gate = 1'($urandom_range(0, 1));
            rcv_gate = 1'($urandom_range(0, 1));
            run_cycle();
            cycles++;
        end
        src_gate = 1'b1;
        rcv_gate = 1'b1;
        check("rand_count", got.size(), 200 * FW);
        check("rand_src_drained", src_q.size(), 0);
        errs = 0;
        for (int j = 0; j < got.size(); j++) if (got[j] !== 8'(j)) errs++;
        check("rand_order_errors", errs, 0);

        // Asynchronous reset at lane 3 discards the rest of the word
        got.delete();
        src_q.push_back(mk_word(8'h60));
        repeat (4) run_cycle();
        sender_empty_n = 1'b0;
        #1;
        check("mid_enq_before_rst", 32'(receiver_enq), 1);
        check("mid_data_before_rst", 32'(receiver_data), 32'h63);
        rst_n = 1'b0;
        #1;
        check("mid_rst_enq", 32'(receiver_enq), 0);
        check("mid_rst_data", 32'(receiver_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        src_q.push_back(mk_word(8'h70));
        repeat (8) run_cycle();
        check("post_rst_count", got.size(), 6);
        check("post_rst_first", (got.size() > 0) ? 32'(got[0]) : 32'hffff, 32'h70);
        check("post_rst_last", (got.size() == 6) ? 32'(got[5]) : 32'hffff, 32'h75);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
